// File: rtl/comp_search_fsm.sv
// Binary-search probe driver for a magnitude comparator: walks input b until the
// comparator reports a==b. Optional iteration counter: define COMP_SEARCH_ITER_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start; probe/result/err held
// SETTLE | probe stable for one cycle while the comparator output settles
// EVAL   | sample comparator flags, narrow the window or finish
// DONE   | one-cycle done pulse, then back to IDLE
module comp_search_fsm #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef COMP_SEARCH_ITER_CNT_EN
    ,
    output logic [$clog2(WIDTH+2)-1:0] iter_cnt
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] EVAL   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   MID_INIT = HI_INIT >> 1;
    localparam logic [WIDTH-1:0] PROBE_MAX = {WIDTH{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH:0] new_lo, new_hi, mid_gt, mid_lt;
    logic           flags_ok;

    // Candidate window bounds after a gt/lt answer; lo/hi carry an extra bit so
    // probe+1 at the top of the range cannot wrap.
    assign new_lo   = {1'b0, probe_q} + 1'b1;
    assign new_hi   = {1'b0, probe_q} - 1'b1;
    assign mid_gt   = new_lo + ((hi_q - new_lo) >> 1);
    assign mid_lt   = lo_q + ((new_hi - lo_q) >> 1);
    assign flags_ok = $onehot({cmp_eq, cmp_gt, cmp_lt});

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    probe_d = MID_INIT[WIDTH-1:0];
                    err_d   = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: state_d = EVAL;
            EVAL: begin
                if (!flags_ok) begin
                    result_d = probe_q;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (cmp_eq) begin
                    result_d = probe_q;
                    state_d  = DONE;
                end else if (cmp_gt) begin
                    if (probe_q == PROBE_MAX || new_lo > hi_q) begin
                        result_d = probe_q;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        lo_d    = new_lo;
                        probe_d = mid_gt[WIDTH-1:0];
                        state_d = SETTLE;
                    end
                end else begin
                    if (probe_q == '0 || lo_q > new_hi) begin
                        result_d = probe_q;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        hi_d    = new_hi;
                        probe_d = mid_lt[WIDTH-1:0];
                        state_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            probe_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

`ifdef COMP_SEARCH_ITER_CNT_EN
    localparam int CW = $clog2(WIDTH+2);
    logic [CW-1:0] iter_q, iter_d;

    always_comb begin
        iter_d = iter_q;
        if (state_q == IDLE && start) begin
            iter_d = '0;
        end else if (state_q == EVAL) begin
            iter_d = iter_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

    assign iter_cnt = iter_q;
`endif

    assign probe  = probe_q;
    assign busy   = (state_q == SETTLE) || (state_q == EVAL);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_comp_search_fsm.sv
// Directed bench for comp_search_fsm (WIDTH=2) with a behavioural comparator
// that can be forced into faulty responses.
module tb_comp_search_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmp_eq, cmp_gt, cmp_lt;
    logic [1:0] probe;
    logic       busy, done, err;
    logic [1:0] result;
`ifdef COMP_SEARCH_ITER_CNT_EN
    logic [1:0] iter_cnt;
`endif

    int target;
    int fmode;      // 0 = honest comparator, 1 = all flags low, 2 = always gt
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign cmp_eq = (fmode == 0) && (target == int'(probe));
    assign cmp_gt = (fmode == 2) || ((fmode == 0) && (target > int'(probe)));
    assign cmp_lt = (fmode == 0) && (target < int'(probe));

    comp_search_fsm #(.WIDTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
`ifdef COMP_SEARCH_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Pulses start, counts rising edges (accepting edge = 1) until done, and
    // records the probe shown in each SETTLE (odd edges) as a 2-bit-per-probe history.
    task automatic run_search(input string tag, input int tgt, input int mode,
                              input bit repulse, input int exp_edges,
                              input int exp_hist, input int exp_res,
                              input int exp_err, input int exp_iter);
        int  edges = 0;
        int  hist  = 0;
        bit  seen  = 1'b0;
        target = tgt;
        fmode  = mode;
        @(posedge clk); #1 start = 1'b1;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            start = repulse && (edges == 2);
            if (edges == 1) chk({tag, ".busy"}, int'(busy), 1);
            if (busy && (edges % 2 == 1)) hist = (hist << 2) | int'(probe);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".done_edges"}, seen ? edges : -1, exp_edges);
        chk({tag, ".probes"}, hist, exp_hist);
        chk({tag, ".result"}, int'(result), exp_res);
        chk({tag, ".err"}, int'(err), exp_err);
`ifdef COMP_SEARCH_ITER_CNT_EN
        chk({tag, ".iter"}, int'(iter_cnt), exp_iter);
`else
        if (exp_iter < 0) $display("note: negative iteration expectation ignored");
`endif
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, int'(done), 0);
        chk({tag, ".result_hold"}, int'(result), exp_res);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = 0;
        fmode  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.probe",  int'(probe),  0);
        chk("rst.busy",   int'(busy),   0);
        chk("rst.done",   int'(done),   0);
        chk("rst.result", int'(result), 0);
        chk("rst.err",    int'(err),    0);
        rst = 1'b0;

        //          tag       tgt mode rep edges hist        res err iter
        run_search("t1",      1,  0,   0,  3,    1,          1,  0,  1);
        run_search("t0",      0,  0,   0,  5,    4'b0100,    0,  0,  2);
        run_search("t3",      3,  0,   0,  7,    6'b011011,  3,  0,  3);
        run_search("nofl",    2,  1,   0,  3,    1,          1,  1,  1);
        run_search("gtmax",   3,  2,   0,  7,    6'b011011,  3,  1,  3);
        run_search("clr",     2,  0,   0,  5,    4'b0110,    2,  0,  2);
        run_search("repulse", 3,  0,   1,  7,    6'b011011,  3,  0,  3);

        // Reset while the second probe is settling.
        target = 3;
        fmode  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.probe2", int'(probe), 2);
        chk("mid.busy",   int'(busy),  1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.probe",  int'(probe),  0);
        chk("abort.busy",   int'(busy),   0);
        chk("abort.done",   int'(done),   0);
        chk("abort.result", int'(result), 0);
        chk("abort.err",    int'(err),    0);
`ifdef COMP_SEARCH_ITER_CNT_EN
        chk("abort.iter",   int'(iter_cnt), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort.nodone", int'(done), 0);

        run_search("after",   2,  0,   0,  5,    4'b0110,    2,  0,  2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
